// File: rtl/line_track_pkg.sv
`default_nettype none
//============================================================================
// Module      : line_track_pkg
// Description : Shared types and codes for the line-following controller:
//               controller state enum, motor speed codes and motor
//               direction (choose) codes.
// Revision    : 1.0 - initial release
//============================================================================
package line_track_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRACK   = 3'd1,
        SEARCH  = 3'd2,
        REVERSE = 3'd3,
        STOP    = 3'd4
    } state_t;

    // speed output codes
    localparam logic [1:0] SPD_STOP = 2'b00;
    localparam logic [1:0] SPD_SLOW = 2'b01;
    localparam logic [1:0] SPD_FAST = 2'b10;

    // motor direction (choose) output codes
    localparam logic [1:0] MOT_BRAKE = 2'b00;
    localparam logic [1:0] MOT_FWD   = 2'b01;
    localparam logic [1:0] MOT_REV   = 2'b10;

endpackage : line_track_pkg
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
//============================================================================
// Module      : sensor_debounce
// Description : Single-bit debouncer. The output level flips only after
//               DEB_CNT consecutive samples that differ from it; any
//               agreeing sample restarts the count.
// Ports       : clk      - sample clock (rising edge)
//               rst      - asynchronous active-low reset
//               i_sample - synchronised input bit
//               o_level  - debounced level
// Revision    : 1.0 - initial release
//============================================================================
module sensor_debounce #(
    parameter int DEB_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sample,
    output logic o_level
);

    // counter only needs to reach DEB_CNT-1: the DEB_CNT-th mismatch flips
    // the level directly instead of being stored
    localparam int                 c_cnt_w = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DEB_CNT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_sample != r_level) begin
            if (r_cnt == c_last) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_level = r_level;

endmodule : sensor_debounce
`default_nettype wire

// File: rtl/line_tracker.sv
`default_nettype none
//============================================================================
// Module      : line_tracker
// Description : Line-following controller. Debounces N_SENS IR sensors,
//               steers proportionally to the centre of the outer active
//               sensors, and on line loss searches, reverses, then stops.
// Ports       : clk_100   - 100 Hz control tick (rising edge)
//               rst       - asynchronous active-low reset
//               switch    - run enable, 0 forces IDLE
//               road_flag - raw sensor bits, MSB leftmost, 1 = line
//               dir       - steering code, 0 full left, CENTER straight
//               speed     - 00 stop, 01 slow, 10 fast
//               choose    - 00 brake, 01 forward, 10 reverse
//               lost      - high only while stopped after failed recovery
// Revision    : 1.0 - initial release
//============================================================================
module line_tracker
    import line_track_pkg::*;
#(
    parameter int N_SENS       = 4,
    parameter int DIR_W        = 3,
    parameter int DEB_CNT      = 4,
    parameter int LOST_TIMEOUT = 200,
    parameter int REV_TICKS    = 100
) (
    input  logic              clk_100,
    input  logic              rst,
    input  logic              switch,
    input  logic [N_SENS-1:0] road_flag,
    output logic [DIR_W-1:0]  dir,
    output logic [1:0]        speed,
    output logic [1:0]        choose,
    output logic              lost
);

    localparam int               c_center_i = (2 ** (DIR_W - 1)) - 1;
    localparam logic [DIR_W-1:0] c_center   = DIR_W'(c_center_i);
    localparam logic [DIR_W-1:0] c_full_r   = DIR_W'(2 * c_center_i);
    localparam int               c_idx_w    = $clog2(N_SENS);
    localparam int               c_cnt_max  = (LOST_TIMEOUT > REV_TICKS) ? LOST_TIMEOUT : REV_TICKS;
    localparam int               c_cnt_w    = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(c_cnt_max);
    localparam logic [c_cnt_w-1:0] c_lost_end = c_cnt_w'(LOST_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_rev_end  = c_cnt_w'(REV_TICKS - 1);

    logic [N_SENS-1:0]  r_sync;
    logic [N_SENS-1:0]  w_deb;
    logic [c_idx_w-1:0] w_hi;
    logic [c_idx_w-1:0] w_lo;
    logic [31:0]        w_sum;
    logic [DIR_W-1:0]   w_dir_track;
    logic [DIR_W-1:0]   w_search_dir;
    logic [DIR_W-1:0]   w_rev_dir;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [DIR_W-1:0]   r_last_dir;
    logic [DIR_W-1:0]   r_dir;
    logic [1:0]         r_speed;
    logic [1:0]         r_choose;
    logic               r_lost;
    logic [DIR_W-1:0]   w_next_dir;
    logic [1:0]         w_next_speed;
    logic [1:0]         w_next_choose;
    logic               w_next_lost;

    //------------------------------------------------------------------
    // Input synchroniser and per-sensor debounce
    //------------------------------------------------------------------
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= road_flag;
        end
    end

    generate
        for (genvar g = 0; g < N_SENS; g++) begin : g_sens
            sensor_debounce #(
                .DEB_CNT (DEB_CNT)
            ) u_deb (
                .clk      (clk_100),
                .rst      (rst),
                .i_sample (r_sync[g]),
                .o_level  (w_deb[g])
            );
        end
    endgenerate

    //------------------------------------------------------------------
    // Outer-sensor priority encoders and proportional scaling.
    // With i = N_SENS-1-bit, i_left + i_right = 2(N_SENS-1) - b_hi - b_lo.
    //------------------------------------------------------------------
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        for (int b = 0; b < N_SENS; b++) begin
            if (w_deb[b]) w_hi = c_idx_w'(b);
        end
        for (int b = N_SENS - 1; b >= 0; b--) begin
            if (w_deb[b]) w_lo = c_idx_w'(b);
        end
    end

    assign w_sum = 32'(2 * (N_SENS - 1)) - 32'(w_hi) - 32'(w_lo);

    // No line at all has no meaningful position; report straight ahead.
    always_comb begin
        if ((w_deb == '0) || (&w_deb)) begin
            w_dir_track = c_center;
        end else begin
            w_dir_track = DIR_W'((w_sum * 32'(2 * c_center_i)) / 32'(2 * (N_SENS - 1)));
        end
    end

    always_comb begin
        if (r_last_dir < c_center) begin
            w_search_dir = '0;
        end else if (r_last_dir > c_center) begin
            w_search_dir = c_full_r;
        end else begin
            w_search_dir = c_center;
        end
    end

    assign w_rev_dir = c_full_r - w_search_dir;

    //------------------------------------------------------------------
    // Controller FSM: next state, then outputs of the state being entered
    // so that every output is registered alongside the state.
    //------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_next_dir    = c_center;
        w_next_speed  = SPD_STOP;
        w_next_choose = MOT_BRAKE;
        w_next_lost   = 1'b0;

        if (!switch) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next_state = TRACK;
                TRACK:   if (w_deb == '0) w_next_state = SEARCH;
                // reacquisition is tested first so it beats a timeout
                SEARCH: begin
                    if (w_deb != '0)             w_next_state = TRACK;
                    else if (r_cnt == c_lost_end) w_next_state = REVERSE;
                end
                REVERSE: begin
                    if (w_deb != '0)            w_next_state = TRACK;
                    else if (r_cnt == c_rev_end) w_next_state = STOP;
                end
                STOP:    w_next_state = STOP;
                default: w_next_state = IDLE;
            endcase
        end

        case (w_next_state)
            TRACK: begin
                w_next_dir    = w_dir_track;
                w_next_speed  = (w_dir_track == c_center) ? SPD_FAST : SPD_SLOW;
                w_next_choose = MOT_FWD;
            end
            SEARCH: begin
                w_next_dir    = w_search_dir;
                w_next_speed  = SPD_SLOW;
                w_next_choose = MOT_FWD;
            end
            REVERSE: begin
                w_next_dir    = w_rev_dir;
                w_next_speed  = SPD_SLOW;
                w_next_choose = MOT_REV;
            end
            STOP: begin
                w_next_lost = 1'b1;
            end
            default: begin
                w_next_dir = c_center;
            end
        endcase
    end

    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last_dir <= c_center;
            r_dir      <= c_center;
            r_speed    <= SPD_STOP;
            r_choose   <= MOT_BRAKE;
            r_lost     <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_dir    <= w_next_dir;
            r_speed  <= w_next_speed;
            r_choose <= w_next_choose;
            r_lost   <= w_next_lost;

            if (w_next_state == TRACK) begin
                r_last_dir <= w_dir_track;
            end

            // restart timing on every state change; park at the top value
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dir    = r_dir;
    assign speed  = r_speed;
    assign choose = r_choose;
    assign lost   = r_lost;

endmodule : line_tracker
`default_nettype wire

// File: tb/tb_line_tracker.sv
`default_nettype none
//============================================================================
// Module      : tb_line_tracker
// Description : Self-checking bench for line_tracker with directed
//               scenarios and randomized sensor patterns compared against
//               a behavioural reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_line_tracker;

    localparam int N      = 4;
    localparam int DW     = 3;
    localparam int DEB    = 4;
    localparam int LOST_T = 20;
    localparam int REV_T  = 10;
    localparam int CEN    = 3;

    localparam int M_IDLE    = 0;
    localparam int M_TRACK   = 1;
    localparam int M_SEARCH  = 2;
    localparam int M_REVERSE = 3;
    localparam int M_STOP    = 4;

    logic          clk_100 = 1'b0;
    logic          rst;
    logic          switch;
    logic [N-1:0]  road_flag;
    logic [DW-1:0] dir;
    logic [1:0]    speed;
    logic [1:0]    choose;
    logic          lost;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [N-1:0] m_sync;
    logic [N-1:0] m_deb;
    int           m_run [N];
    int           m_mode;
    int           m_now;
    int           m_enter;
    int           m_last;
    int           m_dir;
    int           m_speed;
    int           m_choose;
    int           m_lost;

    line_tracker #(
        .N_SENS       (N),
        .DIR_W        (DW),
        .DEB_CNT      (DEB),
        .LOST_TIMEOUT (LOST_T),
        .REV_TICKS    (REV_T)
    ) dut (
        .clk_100   (clk_100),
        .rst       (rst),
        .switch    (switch),
        .road_flag (road_flag),
        .dir       (dir),
        .speed     (speed),
        .choose    (choose),
        .lost      (lost)
    );

    always #5 clk_100 = ~clk_100;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed dir/speed/choose/lost=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {dir, speed, choose, lost};
    endfunction

    task automatic expect_out(input string tag, input int d, input int s, input int c, input int l);
        check(tag, outs(), {3'(d), 2'(s), 2'(c), 1'(l)});
    endtask

    // position: 0 = leftmost sensor; steering proportional to the midpoint
    function automatic int track_dir(input logic [N-1:0] d);
        int il;
        int ir;
        il = -1;
        ir = -1;
        for (int i = 0; i < N; i++) begin
            if (d[N-1-i]) begin
                if (il < 0) il = i;
                ir = i;
            end
        end
        if (il < 0) return CEN;
        return ((il + ir) * 2 * CEN) / (2 * (N - 1));
    endfunction

    task automatic model_reset();
        m_sync   = '0;
        m_deb    = '0;
        for (int b = 0; b < N; b++) m_run[b] = 0;
        m_mode   = M_IDLE;
        m_enter  = m_now;
        m_last   = CEN;
        m_dir    = CEN;
        m_speed  = 0;
        m_choose = 0;
        m_lost   = 0;
    endtask

    // one rising edge; rf/sw are the values present before that edge
    task automatic model_edge(input logic [N-1:0] rf, input logic sw);
        int nxt;
        int sdir;
        m_now++;
        nxt = m_mode;
        if (!sw) begin
            nxt = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE:    nxt = M_TRACK;
                M_TRACK:   if (m_deb == 0) nxt = M_SEARCH;
                M_SEARCH: begin
                    if (m_deb != 0) nxt = M_TRACK;
                    else if (m_now - m_enter == LOST_T) nxt = M_REVERSE;
                end
                M_REVERSE: begin
                    if (m_deb != 0) nxt = M_TRACK;
                    else if (m_now - m_enter == REV_T) nxt = M_STOP;
                end
                default: nxt = m_mode;
            endcase
        end
        if (nxt != m_mode) m_enter = m_now;
        m_mode = nxt;

        sdir   = (m_last < CEN) ? 0 : (m_last > CEN) ? 2 * CEN : CEN;
        m_lost = 0;
        case (m_mode)
            M_TRACK: begin
                m_dir    = track_dir(m_deb);
                m_speed  = (m_dir == CEN) ? 2 : 1;
                m_choose = 1;
                m_last   = m_dir;
            end
            M_SEARCH: begin
                m_dir = sdir; m_speed = 1; m_choose = 1;
            end
            M_REVERSE: begin
                m_dir = 2 * CEN - sdir; m_speed = 1; m_choose = 2;
            end
            M_STOP: begin
                m_dir = CEN; m_speed = 0; m_choose = 0; m_lost = 1;
            end
            default: begin
                m_dir = CEN; m_speed = 0; m_choose = 0;
            end
        endcase

        for (int b = 0; b < N; b++) begin
            if (m_sync[b] != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_deb[b] = ~m_deb[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_sync = rf;
    endtask

    task automatic model_check(input string tag);
        check(tag, outs(), {3'(m_dir), 2'(m_speed), 2'(m_choose), 1'(m_lost)});
    endtask

    // drive inputs, take one edge, compare against the model 1 ns later
    task automatic step(input logic [N-1:0] rf, input logic sw);
        road_flag = rf;
        switch    = sw;
        @(posedge clk_100);
        model_edge(rf, sw);
        #1;
        model_check("model");
    endtask

    // called 1 ns after an edge: reset asserts and releases between edges
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        expect_out("rst_async", CEN, 0, 0, 0);
        #1;
        rst = 1'b1;
    endtask

    task automatic steer(input string tag, input logic [N-1:0] rf,
                         input int od, input int os, input int nd, input int ns);
        for (int k = 1; k <= 6; k++) begin
            step(rf, 1'b1);
            if (k == 5) expect_out({tag, "_e5"}, od, os, 1, 0);
            if (k == 6) expect_out({tag, "_e6"}, nd, ns, 1, 0);
        end
    endtask

    initial begin
        int           r;
        int           len;
        logic [N-1:0] pat;
        logic         sw;

        m_now     = 0;
        rst       = 1'b0;
        switch    = 1'b0;
        road_flag = '0;
        model_reset();
        repeat (2) @(posedge clk_100);
        #1;
        expect_out("reset_state", CEN, 0, 0, 0);
        rst = 1'b1;

        // into SEARCH with no line, then reset mid-SEARCH
        for (int k = 1; k <= 6; k++) step(4'b0000, 1'b1);
        expect_out("pre_rst_search", CEN, 1, 1, 0);
        async_reset();
        for (int k = 1; k <= 6; k++) begin
            step(4'b0110, 1'b1);
            if (k == 5) expect_out("rst_release_e5", CEN, 1, 1, 0);
            if (k == 6) expect_out("rst_release_e6", CEN, 2, 1, 0);
        end

        // proportional steering
        steer("steer_0001", 4'b0001, 3, 2, 6, 1);
        steer("steer_1000", 4'b1000, 6, 1, 0, 1);
        steer("steer_1100", 4'b1100, 0, 1, 1, 1);
        steer("steer_1111", 4'b1111, 1, 1, 3, 2);
        steer("steer_0110", 4'b0110, 3, 2, 3, 2);

        // glitch rejection: 3-tick pulse never reaches the outputs
        for (int k = 1; k <= 13; k++) begin
            step((k <= 3) ? 4'b0001 : 4'b0110, 1'b1);
            expect_out("glitch", CEN, 2, 1, 0);
        end

        // line loss and reacquisition before timeout
        steer("steer_0011", 4'b0011, 3, 2, 5, 1);
        for (int k = 1; k <= 14; k++) begin
            step(4'b0000, 1'b1);
            if (k == 6) expect_out("loss_search", 6, 1, 1, 0);
        end
        for (int k = 1; k <= 6; k++) begin
            step(4'b0010, 1'b1);
            if (k == 5) expect_out("reacq_e5", 6, 1, 1, 0);
            if (k == 6) expect_out("reacq_e6", 4, 1, 1, 0);
        end

        // full recovery failure: SEARCH -> REVERSE -> STOP -> IDLE
        for (int k = 1; k <= 37; k++) begin
            step(4'b0000, 1'b1);
            if (k == 6)  expect_out("fail_search", 6, 1, 1, 0);
            if (k == 25) expect_out("fail_search_last", 6, 1, 1, 0);
            if (k == 26) expect_out("fail_reverse", 0, 1, 2, 0);
            if (k == 35) expect_out("fail_reverse_last", 0, 1, 2, 0);
            if (k == 36) expect_out("fail_stop", CEN, 0, 0, 1);
            if (k == 37) expect_out("fail_stop_hold", CEN, 0, 0, 1);
        end
        step(4'b0000, 1'b0);
        expect_out("stop_to_idle", CEN, 0, 0, 0);

        // reacquisition on the same edge as the SEARCH timeout
        for (int k = 1; k <= 6; k++) step(4'b0100, 1'b1);
        expect_out("track_0100", 2, 1, 1, 0);
        for (int k = 1; k <= 26; k++) begin
            step((k <= 20) ? 4'b0000 : 4'b0001, 1'b1);
            if (k == 25) expect_out("tie_search", 0, 1, 1, 0);
            if (k == 26) expect_out("tie_reacq", 6, 1, 1, 0);
        end

        // switch off during REVERSE
        for (int k = 1; k <= 28; k++) begin
            step(4'b0000, 1'b1);
            if (k == 26) expect_out("rev_enter", 0, 1, 2, 0);
        end
        step(4'b0000, 1'b0);
        expect_out("rev_switch_off", CEN, 0, 0, 0);

        // randomized sensor patterns, switch drops and resets
        for (int seg = 0; seg < 160; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                async_reset();
            end else begin
                sw = ($urandom_range(0, 99) < 8) ? 1'b0 : 1'b1;
                if (r < 28) begin
                    pat = '0;
                    len = $urandom_range(5, 40);
                end else begin
                    pat = N'($urandom_range(0, 15));
                    len = $urandom_range(1, 12);
                end
                repeat (len) step(pat, sw);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_line_tracker
`default_nettype wire

// File: doc/line_tracker.md
# line_tracker

Parametrised line-following controller for N_SENS infrared reflective sensors. It debounces the sensor vector and derives a proportional steering code from the positions of the outer active sensors. A lost-line recovery state machine handles line loss: search in the last known direction, then reverse, then stop. It sits between the IR sensor pins and the servo/motor drivers, clocked from the 100 Hz control tick, and replaces the fixed two-sensor follower.

## Interface
- N_SENS, 4: number of IR sensors, ≥2. Bit N_SENS-1 is leftmost, bit 0 is rightmost.
- DIR_W, 3: steering code width. CENTER = 2^(DIR_W-1)-1, full left = 0, full right = 2·CENTER.
- DEB_CNT, 4: consecutive differing samples required to flip a debounced sensor bit, ≥1.
- LOST_TIMEOUT, 200: ticks spent in SEARCH before reversing.
- REV_TICKS, 100: ticks spent in REVERSE before stopping.

Ports:
- clk_100, in, 1: control tick clock. All logic is on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- switch, in, 1: run enable. 0 forces IDLE.
- road_flag, in, N_SENS: raw sensor bits, 1 = black line under sensor.
- dir, out, DIR_W: servo steering code.
- speed, out, 2: 00 stop, 01 slow, 10 fast.
- choose, out, 2: 00 brake, 01 forward, 10 reverse.
- lost, out, 1: high only in STOP.

## Operation
- **Input sync:** road_flag is registered once (sync stage).
- **Debounce:** per bit, a counter increments while the sync bit ≠ the debounced bit and clears otherwise. The debounced bit flips on the DEB_CNT-th consecutive mismatch, and the counter then clears.
- **Position:** taken from the debounced vector d. Let i = N_SENS-1-bit index (0 = leftmost). s = i_leftmost_active + i_rightmost_active, range 0..2(N_SENS-1).
  - dir_track = floor(s·2·CENTER / (2(N_SENS-1))).
  - The all-ones vector (cross line) yields CENTER.
- **States:**
  - IDLE: dir=CENTER, speed=00, choose=00. Go to TRACK when switch=1.
  - TRACK: dir=dir_track, choose=01. speed=10 if dir_track=CENTER, else 01. last_dir ← dir_track every cycle. If d=0, go to SEARCH.
  - SEARCH: dir = 0 if last_dir<CENTER, 2·CENTER if last_dir>CENTER, CENTER if equal. speed=01, choose=01. Tick counter runs.
    - d≠0 → TRACK.
    - counter=LOST_TIMEOUT-1 → REVERSE, counter cleared.
  - REVERSE: dir = 2·CENTER - SEARCH dir (mirrored). speed=01, choose=10.
    - d≠0 → TRACK.
    - counter=REV_TICKS-1 → STOP.
  - STOP: dir=CENTER, speed=00, choose=00, lost=1. Exit only via switch=0 → IDLE.
- **Priority:** switch=0 overrides every state and takes effect on the same edge.
- **Simultaneous events:** if line reacquisition and timeout occur on the same edge, reacquisition wins.
- **Tick counter:** clears on every state change and never wraps. It saturates at its terminal value and is sized to hold max(LOST_TIMEOUT, REV_TICKS).
- **Reset (any time, including mid-SEARCH):**
  - state=IDLE, dir=CENTER, speed=00, choose=00, lost=0.
  - Debounced bits, sync register and counters = 0. last_dir=CENTER.

## Timing
- All outputs are registered and change only on clk_100 edges.
- A road_flag change held stable is captured at edge 1, the debounced bit flips at edge DEB_CNT+1, and outputs reflect it at edge DEB_CNT+2.
- Glitches shorter than DEB_CNT ticks never reach the outputs.
- State transitions take one edge. TRACK→SEARCH outputs appear on the edge after d becomes 0.
- The SEARCH→REVERSE outputs appear exactly LOST_TIMEOUT edges after SEARCH is entered. REVERSE→STOP outputs likewise appear REV_TICKS edges after REVERSE is entered.

## Structure
- Package line_track_pkg holds:
  - state enum: IDLE, TRACK, SEARCH, REVERSE, STOP;
  - speed codes: SPD_STOP, SPD_SLOW, SPD_FAST;
  - choose codes: MOT_BRAKE, MOT_FWD, MOT_REV.
- Sub-module sensor_debounce: 1-bit, parameter DEB_CNT, instantiated N_SENS times in a generate loop.
- Leftmost/rightmost priority encoders and the dir_track scaling stay in line_tracker.

## Test plan
Defaults: N_SENS=4, DIR_W=3, DEB_CNT=4, LOST_TIMEOUT=20, REV_TICKS=10.
- **Reset:** drive rst low mid-SEARCH → dir=011, speed=00, choose=00, lost=0 immediately. Release with switch=1 and road_flag=0110 → at edge 6: dir=011, speed=10, choose=01.
- **Proportional steering:** road_flag 0001 → dir=110, speed=01. 1000 → dir=000. 1100 → dir=001. 1111 → dir=011, speed=10. Each update appears 6 edges after the input change.
- **Glitch rejection:** 0110 steady, pulse 0001 for 3 ticks → dir stays 011 throughout.
- **Line loss:** from 0011 (dir=101), drive 0000 → SEARCH with dir=110, speed=01, choose=01. Restore 0010 at tick 15 → TRACK, dir=100.
- **Full recovery failure:** hold 0000 → REVERSE after 20 ticks (dir=000, choose=10), then STOP after 10 more ticks (lost=1, speed=00). switch=0 → IDLE, lost=0.
- **Priority:** line reappears on the same edge as the SEARCH timeout → TRACK. switch=0 during REVERSE → IDLE on the next edge.
